// File: rtl/scoreboard_reader.sv
// Scans a small score RAM once per request, keeps a local copy of every
// user's score, tracks the leader and answers rank queries from that copy.
module scoreboard_reader #(
  parameter int NUM_USERS  = 6,
  parameter int RD_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scanStart,
  input  logic [7:0] ramData,
  input  logic [2:0] queryUser,
  output logic [2:0] ramAddr,
  output logic       busy,
  output logic       scanDone,
  output logic       scoresValid,
  output logic [7:0] bestScore,
  output logic [2:0] bestUser,
  output logic [2:0] queryRank
);

  // Wait counter spans 0..RD_LATENCY; the address is held for RD_LATENCY+1 cycles.
  localparam int CNT_W = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RD_LATENCY);
  localparam logic [2:0]       ADDR_LAST = 3'(NUM_USERS - 1);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [7:0]       cache [NUM_USERS];
  logic             capture;
  logic             last_user;
  logic [2:0]       rank_cnt;

  // Data is valid on the last cycle of each address window.
  assign capture   = (state == READ) && (wait_cnt == CNT_LAST);
  assign last_user = (ramAddr == ADDR_LAST);

  // State register; reset discards any scan in progress.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    scanDone  = 1'b0;
    case (state)
      IDLE: if (scanStart) state_nxt = READ;
      READ: begin
        busy = 1'b1;
        if (capture && last_user) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        scanDone  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address sequencing, score capture into the cache and leader tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt    <= '0;
      ramAddr     <= 3'd0;
      scoresValid <= 1'b0;
      bestScore   <= 8'h00;
      bestUser    <= 3'd0;
      for (int i = 0; i < NUM_USERS; i++) cache[i] <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (scanStart) begin
            wait_cnt    <= '0;
            ramAddr     <= 3'd0;
            scoresValid <= 1'b0;
            bestScore   <= 8'h00;
            bestUser    <= 3'd0;
          end
        end
        READ: begin
          if (capture) begin
            wait_cnt       <= '0;
            cache[ramAddr] <= ramData;
            // Strictly greater keeps the lower user ID on a tie.
            if (ramData > bestScore) begin
              bestScore <= ramData;
              bestUser  <= ramAddr;
            end
            if (last_user) begin
              ramAddr     <= 3'd0;
              scoresValid <= 1'b1;
            end else begin
              ramAddr <= ramAddr + 3'd1;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Rank = number of cached scores strictly above the queried user's score.
  always_comb begin
    rank_cnt  = 3'd0;
    queryRank = 3'd7;
    if (scoresValid && (int'(queryUser) < NUM_USERS)) begin
      for (int i = 0; i < NUM_USERS; i++) begin
        if (cache[i] > cache[queryUser]) rank_cnt = rank_cnt + 3'd1;
      end
      queryRank = rank_cnt;
    end
  end

endmodule

// File: tb/tb_scoreboard_reader.sv
// Bench for scoreboard_reader: a 2-cycle-latency RAM model feeds the DUT,
// expected scan results are queued at scan start and compared at scanDone.
module tb_scoreboard_reader;

  logic       clk_tb = 1'b0;
  logic       rst;
  logic       scanStart;
  logic [2:0] queryUser;
  logic [2:0] ramAddr;
  logic       busy, scanDone, scoresValid;
  logic [7:0] bestScore;
  logic [2:0] bestUser, queryRank;

  logic [7:0] ram [6];
  logic [7:0] rd_p0, rd_p1;

  typedef struct packed {
    logic [7:0]      best;
    logic [2:0]      user;
    logic [7:0][2:0] rank;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk_tb = ~clk_tb;

  scoreboard_reader #(.NUM_USERS(6), .RD_LATENCY(2)) dut (
    .clk(clk_tb), .rst(rst), .scanStart(scanStart), .ramData(rd_p1),
    .queryUser(queryUser), .ramAddr(ramAddr), .busy(busy),
    .scanDone(scanDone), .scoresValid(scoresValid), .bestScore(bestScore),
    .bestUser(bestUser), .queryRank(queryRank)
  );

  // Synchronous RAM with two cycles of read latency.
  always @(posedge clk_tb) begin
    rd_p0 <= (ramAddr < 3'd6) ? ram[ramAddr] : 8'h00;
    rd_p1 <= rd_p0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    e.best = 8'h00;
    e.user = 3'd0;
    for (int j = 0; j < 6; j++)
      if (ram[j] > e.best) begin e.best = ram[j]; e.user = 3'(j); end
    for (int u = 0; u < 8; u++) begin
      if (u >= 6) e.rank[u] = 3'd7;
      else begin
        e.rank[u] = 3'd0;
        for (int j = 0; j < 6; j++) if (ram[j] > ram[u]) e.rank[u] = e.rank[u] + 3'd1;
      end
    end
    return e;
  endfunction

  task automatic set_ram(input logic [7:0] a0, a1, a2, a3, a4, a5);
    ram[0] = a0; ram[1] = a1; ram[2] = a2; ram[3] = a3; ram[4] = a4; ram[5] = a5;
  endtask

  // Runs one scan. Cycle 1 is the cycle after the edge sampling scanStart.
  // extra_cyc: cycle holding a spurious scanStart; rst_cyc: cycle holding rst low.
  task automatic do_scan(input int extra_cyc, input int rst_cyc);
    exp_t e;
    bit   done_seen = 0;
    exp_q.push_back(model());
    @(negedge clk_tb);
    scanStart = 1'b1;
    @(negedge clk_tb);
    scanStart = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc > 1) @(negedge clk_tb);
      scanStart = (cyc == extra_cyc);
      if (cyc <= 18) begin
        check($sformatf("addr_c%0d", cyc), ramAddr, (cyc - 1) / 3);
        if (cyc == 1 || cyc == 18) begin
          check($sformatf("busy_c%0d", cyc), busy, 1);
          check($sformatf("valid_low_c%0d", cyc), scoresValid, 0);
        end
      end
      if (cyc == rst_cyc) begin
        rst = 1'b0;
        @(negedge clk_tb);
        rst = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_addr", ramAddr, 0);
        check("rst_valid", scoresValid, 0);
        check("rst_best", bestScore, 8'h00);
        check("rst_user", bestUser, 0);
        queryUser = 3'd5;
        #1 check("rst_rank", queryRank, 7);
        void'(exp_q.pop_back());
        @(negedge clk_tb);
        check("rst_idle", busy, 0);
        return;
      end
      if (scanDone) begin
        check("done_cycle", cyc, 19);
        check("done_addr", ramAddr, 0);
        done_seen = 1;
        break;
      end
    end
    scanStart = 1'b0;
    if (!done_seen) begin
      check("done_timeout", 0, 1);
      return;
    end
    if (exp_q.size() == 0) begin
      check("queue_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check("valid", scoresValid, 1);
    check("best_score", bestScore, e.best);
    check("best_user", bestUser, e.user);
    @(negedge clk_tb);
    check("post_busy", busy, 0);
    check("post_done", scanDone, 0);
    check("post_valid", scoresValid, 1);
    for (int u = 0; u < 8; u++) begin
      queryUser = 3'(u);
      #1 check($sformatf("rank_u%0d", u), queryRank, e.rank[u]);
    end
  endtask

  task automatic rank_is(input int u, input int r);
    queryUser = 3'(u);
    #1 check($sformatf("const_rank_u%0d", u), queryRank, r);
  endtask

  initial begin
    rst = 1'b0;
    scanStart = 1'b1;   // must be ignored while reset is held
    queryUser = 3'd0;
    set_ram(8'h00, 8'hC8, 8'h00, 8'h1B, 8'h00, 8'hE5);
    repeat (3) @(negedge clk_tb);
    check("reset_busy", busy, 0);
    check("reset_addr", ramAddr, 0);
    check("reset_done", scanDone, 0);
    check("reset_valid", scoresValid, 0);
    check("reset_best", bestScore, 0);
    check("reset_user", bestUser, 0);
    check("reset_rank", queryRank, 7);
    rst = 1'b1;
    scanStart = 1'b0;
    @(negedge clk_tb);
    check("idle_after_reset", busy, 0);

    // Nominal scan with an ignored scanStart in cycle 5.
    do_scan(5, 0);
    check("nom_best", bestScore, 8'hE5);
    check("nom_user", bestUser, 5);
    rank_is(5, 0); rank_is(1, 1); rank_is(3, 2); rank_is(0, 3); rank_is(6, 7);
    @(negedge clk_tb);
    check("no_restart", busy, 0);

    // All-zero ties.
    set_ram(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    do_scan(0, 0);
    check("zero_user", bestUser, 0);
    check("zero_best", bestScore, 0);
    for (int u = 0; u < 6; u++) rank_is(u, 0);

    // Tie between users 2 and 4.
    set_ram(8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h00);
    do_scan(0, 0);
    check("tie_user", bestUser, 2);

    // Reset in cycle 8, then a clean scan.
    set_ram(8'h00, 8'hC8, 8'h00, 8'h1B, 8'h00, 8'hE5);
    do_scan(0, 8);
    do_scan(0, 0);
    check("after_rst_best", bestScore, 8'hE5);
    check("after_rst_user", bestUser, 5);

    // Rescan after updating user 1.
    ram[1] = 8'hF0;
    do_scan(0, 0);
    check("upd_user", bestUser, 1);
    check("upd_best", bestScore, 8'hF0);
    rank_is(5, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
